// File: rtl/sha_pkg.sv
// Shared sizing, constants and helper functions for the single-block SHA-256 engine.
// Read by the sha top and the sha_round datapath.
package sha_const;

   localparam int Nk = 256;
   localparam int Nl = 3;
   localparam int Nd = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2
   } state_t;

   typedef logic [7:0] msg_t [0:Nl-1];

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Message bytes, the 0x80 marker, zero fill, then the 64-bit big-endian bit length.
   function automatic logic [511:0] pad_block(input msg_t d);
      logic [511:0] blk;
      logic [63:0]  len;
      blk = '0;
      len = 64'(Nl) * 64'd8;
      for (int i = 0; i < Nl; i++) begin
         blk[511 - 8*i -: 8] = d[i];
      end
      blk[511 - 8*Nl -: 8] = 8'h80;
      blk[63:0] = len;
      return blk;
   endfunction

endpackage

// File: rtl/sha_round.sv
// One combinational SHA-256 compression round: working variables a..h plus Kt and Wt
// in, next a..h out.
module sha_round
   import sha_const::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   input  logic [31:0] d,
   input  logic [31:0] e,
   input  logic [31:0] f,
   input  logic [31:0] g,
   input  logic [31:0] h,
   input  logic [31:0] kt,
   input  logic [31:0] wt,
   output logic [31:0] a_n,
   output logic [31:0] b_n,
   output logic [31:0] c_n,
   output logic [31:0] d_n,
   output logic [31:0] e_n,
   output logic [31:0] f_n,
   output logic [31:0] g_n,
   output logic [31:0] h_n
);

   logic [31:0] ch;
   logic [31:0] maj;
   logic [31:0] t1;
   logic [31:0] t2;

   assign ch  = (e & f) ^ (~e & g);
   assign maj = (a & b) ^ (a & c) ^ (b & c);
   assign t1  = h + big_sigma1(e) + ch + kt + wt;
   assign t2  = big_sigma0(a) + maj;

   assign a_n = t1 + t2;
   assign b_n = a;
   assign c_n = b;
   assign d_n = c;
   assign e_n = d + t1;
   assign f_n = e;
   assign g_n = f;
   assign h_n = g;

endmodule

// File: rtl/sha.sv
// Single-block SHA-256 engine: IDLE -> ROUND x64 (x32 with two rounds per cycle) -> FINAL.
// Define SHA_UNROLL_EN to instantiate a second sha_round and halve the ROUND phase.
module sha
   import sha_const::*;
(
   input  logic          clk,
   input  logic          rst,
   input  msg_t          Data,
   input  logic          Enable,
   output logic [Nk-1:0] Hash,
   output logic          Ready,
   output state_t        dbg_state
);

`ifdef SHA_UNROLL_EN
   localparam logic [5:0] RND_STEP = 6'd2;
   localparam logic [5:0] RND_LAST = 6'd62;
`else
   localparam logic [5:0] RND_STEP = 6'd1;
   localparam logic [5:0] RND_LAST = 6'd63;
`endif

   state_t       state;
   logic [5:0]   rnd;
   logic [31:0]  w  [0:15];
   logic [31:0]  v  [0:7];
   logic [31:0]  r1 [0:7];
   logic [31:0]  nxt [0:7];
   logic [511:0] blk;
   logic [31:0]  nw0;

   assign blk       = pad_block(Data);
   assign dbg_state = state;

   // Next schedule word derived from the 16-word window: W[t+16] from W[t..t+15].
   assign nw0 = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];

   sha_round u_round0 (
      .a(v[0]), .b(v[1]), .c(v[2]), .d(v[3]),
      .e(v[4]), .f(v[5]), .g(v[6]), .h(v[7]),
      .kt(K[rnd]), .wt(w[0]),
      .a_n(r1[0]), .b_n(r1[1]), .c_n(r1[2]), .d_n(r1[3]),
      .e_n(r1[4]), .f_n(r1[5]), .g_n(r1[6]), .h_n(r1[7])
   );

`ifdef SHA_UNROLL_EN
   logic [31:0] nw1;
   logic [5:0]  rnd_odd;

   assign nw1     = small_sigma1(w[15]) + w[10] + small_sigma0(w[2]) + w[1];
   assign rnd_odd = rnd + 6'd1;

   sha_round u_round1 (
      .a(r1[0]), .b(r1[1]), .c(r1[2]), .d(r1[3]),
      .e(r1[4]), .f(r1[5]), .g(r1[6]), .h(r1[7]),
      .kt(K[rnd_odd]), .wt(w[1]),
      .a_n(nxt[0]), .b_n(nxt[1]), .c_n(nxt[2]), .d_n(nxt[3]),
      .e_n(nxt[4]), .f_n(nxt[5]), .g_n(nxt[6]), .h_n(nxt[7])
   );
`else
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         nxt[k] = r1[k];
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         Ready <= 1'b0;
         Hash  <= '0;
         rnd   <= '0;
      end else begin
         Ready <= 1'b0;
         case (state)
            IDLE: begin
               if (Enable) begin
                  for (int k = 0; k < 16; k++) begin
                     w[k] <= blk[511 - 32*k -: 32];
                  end
                  for (int k = 0; k < 8; k++) begin
                     v[k] <= IV[k];
                  end
                  rnd   <= '0;
                  state <= ROUND;
               end
            end
            ROUND: begin
               for (int k = 0; k < 8; k++) begin
                  v[k] <= nxt[k];
               end
`ifdef SHA_UNROLL_EN
               for (int k = 0; k < 14; k++) begin
                  w[k] <= w[k+2];
               end
               w[14] <= nw0;
               w[15] <= nw1;
`else
               for (int k = 0; k < 15; k++) begin
                  w[k] <= w[k+1];
               end
               w[15] <= nw0;
`endif
               rnd <= rnd + RND_STEP;
               if (rnd == RND_LAST) begin
                  state <= FINAL;
               end
            end
            FINAL: begin
               for (int k = 0; k < 8; k++) begin
                  Hash[255 - 32*k -: 32] <= IV[k] + v[k];
               end
               Ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha.sv
// Directed bench for sha: "abc" digest, latency, Enable/Data/reset corner cases.
// Build with SHA_UNROLL_EN defined to exercise the two-rounds-per-cycle variant.
module tb_sha;
   import sha_const::*;

`ifdef SHA_UNROLL_EN
   localparam int LAT = 33;
`else
   localparam int LAT = 65;
`endif
   localparam logic [255:0] ABC_HASH =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

   logic          clk;
   logic          rst;
   msg_t          data;
   logic          enable;
   logic [Nk-1:0] hash;
   logic          ready;
   state_t        dbg_state;

   int passed;
   int total;
   int cyc;
   int ready_cnt;
   int ready_cyc;
   int t_start;
   int r_first;
   int cnt0;

   sha dut (
      .clk(clk),
      .rst(rst),
      .Data(data),
      .Enable(enable),
      .Hash(hash),
      .Ready(ready),
      .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout obs=running exp=finished");
      $fatal(1, "global timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (ready) begin
         ready_cnt++;
         ready_cyc = cyc;
      end
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
   endtask

   task automatic set_abc();
      data[0] = 8'h61;
      data[1] = 8'h62;
      data[2] = 8'h63;
   endtask

   task automatic start();
      enable = 1'b1;
      tick();
      t_start = cyc;
      enable = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int c0;
      bit got;
      c0  = ready_cnt;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         tick();
         if (ready_cnt != c0) got = 1'b1;
      end
      chk({tag, "_ready_seen"}, 256'(got), 256'd1);
   endtask

   initial begin
      passed    = 0;
      total     = 0;
      cyc       = 0;
      ready_cnt = 0;
      ready_cyc = 0;
      rst       = 1'b0;
      enable    = 1'b0;
      set_abc();

      // Reset state
      tick();
      tick();
      chk("reset_hash", hash, 256'd0);
      chk("reset_ready", 256'(ready), 256'd0);
      chk("reset_state", 256'(dbg_state), 256'(IDLE));
      rst = 1'b1;
      tick();

      // Basic "abc" digest and latency
      cnt0 = ready_cnt;
      start();
      chk("run_state", 256'(dbg_state), 256'(ROUND));
      wait_ready("basic");
      chk("basic_latency", 256'(ready_cyc - t_start), 256'(LAT));
      chk("basic_hash", hash, ABC_HASH);
      tick();
      chk("basic_pulse_width", 256'(ready), 256'd0);
      for (int i = 0; i < 5; i++) tick();
      chk("basic_hash_hold", hash, ABC_HASH);
      chk("basic_one_pulse", 256'(ready_cnt - cnt0), 256'd1);

      // Reset at T+30 aborts, with Enable during reset ignored
      cnt0 = ready_cnt;
      start();
      while (cyc < t_start + 29) tick();
      rst    = 1'b0;
      enable = 1'b1;
      tick();
      rst    = 1'b1;
      enable = 1'b0;
      chk("abort_state", 256'(dbg_state), 256'(IDLE));
      for (int i = 0; i < 80; i++) tick();
      chk("abort_no_ready", 256'(ready_cnt - cnt0), 256'd0);
      chk("abort_hash_zero", hash, 256'd0);
      start();
      wait_ready("after_abort");
      chk("after_abort_hash", hash, ABC_HASH);
      chk("after_abort_latency", 256'(ready_cyc - t_start), 256'(LAT));

      // Clear Hash, then change Data to "xyz" at T+5
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("clear_hash", hash, 256'd0);
      start();
      while (cyc < t_start + 4) tick();
      data[0] = 8'h78;
      data[1] = 8'h79;
      data[2] = 8'h7a;
      wait_ready("data_change");
      chk("data_change_hash", hash, ABC_HASH);
      set_abc();

      // Enable pulsed again at T+10 during ROUND
      rst = 1'b0;
      tick();
      rst = 1'b1;
      cnt0 = ready_cnt;
      start();
      while (cyc < t_start + 9) tick();
      enable = 1'b1;
      tick();
      enable = 1'b0;
      wait_ready("mid_enable");
      chk("mid_enable_latency", 256'(ready_cyc - t_start), 256'(LAT));
      chk("mid_enable_hash", hash, ABC_HASH);
      for (int i = 0; i < 90; i++) tick();
      chk("mid_enable_one_pulse", 256'(ready_cnt - cnt0), 256'd1);

      // Enable high during the FINAL cycle is ignored
      cnt0 = ready_cnt;
      start();
      while (cyc < t_start + LAT - 1) tick();
      chk("final_state", 256'(dbg_state), 256'(FINAL));
      enable = 1'b1;
      tick();
      enable = 1'b0;
      chk("final_ready", 256'(ready), 256'd1);
      for (int i = 0; i < 90; i++) tick();
      chk("final_enable_ignored", 256'(ready_cnt - cnt0), 256'd1);
      chk("final_idle", 256'(dbg_state), 256'(IDLE));

      // Back-to-back: Enable one cycle after the Ready cycle
      rst = 1'b0;
      tick();
      rst = 1'b1;
      start();
      wait_ready("b2b_first");
      r_first = ready_cyc;
      chk("b2b_first_hash", hash, ABC_HASH);
      tick();
      start();
      while (cyc < t_start + LAT / 2) tick();
      chk("b2b_hash_stable", hash, ABC_HASH);
      wait_ready("b2b_second");
      chk("b2b_spacing", 256'(ready_cyc - r_first), 256'(LAT + 2));
      chk("b2b_second_hash", hash, ABC_HASH);

      // Enable held high restarts from the first IDLE cycle
      enable = 1'b1;
      tick();
      t_start = cyc;
      wait_ready("held_first");
      r_first = ready_cyc;
      chk("held_first_latency", 256'(r_first - t_start), 256'(LAT));
      wait_ready("held_second");
      enable = 1'b0;
      chk("held_spacing", 256'(ready_cyc - r_first), 256'(LAT + 1));
      chk("held_hash", hash, ABC_HASH);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
